// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: receive-side VGA timing monitor and mode lock.
// Define VGA_DEC_CRC_EN to add rgb input and a per-frame CRC-16 output.
module vga_timing_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int SYNC_ACT_LOW = 1,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank_n,
`ifdef VGA_DEC_CRC_EN
    input  logic [23:0] rgb,
    output logic [15:0] frame_crc,
`endif
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic        px_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        err_sticky,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_v_total
);

    localparam logic [10:0] HA = 11'(H_ACTIVE);
    localparam logic [10:0] VA = 11'(V_ACTIVE);
    localparam logic [10:0] HT = 11'(H_TOTAL);
    localparam logic [10:0] VT = 11'(V_TOTAL);
    localparam logic [3:0]  LF = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQ,
        ST_LOCKED
    } state_t;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  good_q, good_d, good_inc;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, bl1_q, bl1_d;
    logic        hsp_q, hsp_d, vsp_q, vsp_d;
    logic        arm1_q, arm1_d, arm2_q, arm2_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [10:0] meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic [10:0] x_cur, y_cur;
    logic        line_act_q, line_act_d;
    logic [9:0]  px_x_q, px_x_d;
    logic        px_valid_q, px_valid_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic        hs_edge, vs_edge, in_range, excess;
    logic        h_bad, v_bad;

    // Input capture: normalise sync polarity and arm edge detect after reset
    always_comb begin
        hs1_d  = (SYNC_ACT_LOW != 0) ? ~hs : hs;
        vs1_d  = (SYNC_ACT_LOW != 0) ? ~vs : vs;
        bl1_d  = blank_n;
        hsp_d  = hs1_q;
        vsp_d  = vs1_q;
        arm1_d = 1'b1;
        arm2_d = arm1_q;
    end

    // Counters, measurements and pixel coordinates; VS handled before HS
    always_comb begin
        hs_edge  = hs1_q & ~hsp_q & arm2_q;
        vs_edge  = vs1_q & ~vsp_q & arm2_q;
        hcnt_d   = hs_edge ? 11'd0 : sat_inc(hcnt_q);
        meas_h_d = hs_edge ? sat_inc(hcnt_q) : meas_h_q;
        vcnt_d   = vcnt_q;
        if (vs_edge)
            vcnt_d = 11'd0;
        else if (hs_edge)
            vcnt_d = sat_inc(vcnt_q);
        meas_v_d = vs_edge ? vcnt_q : meas_v_q;
        x_cur    = hs_edge ? 11'd0 : xcnt_q;
        y_cur    = ycnt_q;
        if (vs_edge)
            y_cur = 11'd0;
        else if (hs_edge && line_act_q)
            y_cur = sat_inc(ycnt_q);
        xcnt_d     = bl1_q ? sat_inc(x_cur) : x_cur;
        ycnt_d     = y_cur;
        line_act_d = bl1_q | (~hs_edge & line_act_q);
        in_range   = (x_cur < HA) && (y_cur < VA);
        excess     = bl1_q & ~in_range;
        px_x_d     = px_x_q;
        if (bl1_q)
            px_x_d = x_cur[9:0];
        else if (hs_edge)
            px_x_d = 10'd0;
        px_valid_d    = bl1_q & locked_q & in_range;
        line_start_d  = hs_edge;
        frame_start_d = vs_edge;
        locked_d      = (state_q == ST_LOCKED);
    end

    // Lock FSM: acquire on matching frames, drop and flag on any mismatch
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = err_q;
        good_inc = good_q + 4'd1;
        h_bad    = hs_edge && (meas_h_d != HT);
        v_bad    = vs_edge && (vcnt_q != VT);
        unique case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d = ST_ACQ;
                    good_d  = 4'd0;
                end
            end
            ST_ACQ: begin
                if (vs_edge) begin
                    if (v_bad || (meas_h_d != HT)) begin
                        good_d = 4'd0;
                    end else if (good_inc >= LF) begin
                        state_d = ST_LOCKED;
                        good_d  = 4'd0;
                    end else begin
                        good_d = good_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_bad || v_bad || excess) begin
                    state_d = ST_SEARCH;
                    good_d  = 4'd0;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            good_q        <= 4'd0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            bl1_q         <= 1'b0;
            hsp_q         <= 1'b0;
            vsp_q         <= 1'b0;
            arm1_q        <= 1'b0;
            arm2_q        <= 1'b0;
            hcnt_q        <= 11'd0;
            vcnt_q        <= 11'd0;
            xcnt_q        <= 11'd0;
            ycnt_q        <= 11'd0;
            meas_h_q      <= 11'd0;
            meas_v_q      <= 11'd0;
            line_act_q    <= 1'b0;
            px_x_q        <= 10'd0;
            px_valid_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            bl1_q         <= bl1_d;
            hsp_q         <= hsp_d;
            vsp_q         <= vsp_d;
            arm1_q        <= arm1_d;
            arm2_q        <= arm2_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            xcnt_q        <= xcnt_d;
            ycnt_q        <= ycnt_d;
            meas_h_q      <= meas_h_d;
            meas_v_q      <= meas_v_d;
            line_act_q    <= line_act_d;
            px_x_q        <= px_x_d;
            px_valid_q    <= px_valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign px_x         = px_x_q;
    assign px_y         = ycnt_q[9:0];
    assign px_valid     = px_valid_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign locked       = locked_q;
    assign err_sticky   = err_q;
    assign meas_h_total = meas_h_q;
    assign meas_v_total = meas_v_q;

`ifdef VGA_DEC_CRC_EN
    function automatic logic [15:0] crc24(input logic [15:0] c_in,
                                          input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb)
                c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [23:0] rgb1_q, rgb1_d;
    logic [15:0] crc_q, crc_d, crc_base;
    logic [15:0] fcrc_q, fcrc_d;

    // Running CRC over valid pixels, snapshotted and restarted at frame start
    always_comb begin
        rgb1_d   = rgb;
        crc_base = vs_edge ? 16'hFFFF : crc_q;
        crc_d    = px_valid_d ? crc24(crc_base, rgb1_q) : crc_base;
        fcrc_d   = vs_edge ? crc_q : fcrc_q;
    end

    // CRC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb1_q <= 24'd0;
            crc_q  <= 16'hFFFF;
            fcrc_q <= 16'h0000;
        end else begin
            rgb1_q <= rgb1_d;
            crc_q  <= crc_d;
            fcrc_q <= fcrc_d;
        end
    end

    assign frame_crc = fcrc_q;
`endif

endmodule
